reg_file_mp: RTL and testbench

Parametrised multi-read-port register file with write-through bypass and an integrated per-register scoreboard. It replaces the fixed 32x32, two-read-port register file in the datapath and adds synchronous reset, configurable width, depth and read-port count, and same-cycle forwarding. Pending-write tracking gives the pipelined control unit a direct read-after-write hazard indication. Register 0 is hardwired to zero.

---
 rtl/reg_file_pkg.sv | 13 +
 rtl/reg_scoreboard.sv | 56 +++++
 rtl/reg_file_mp.sv | 72 +++++++
 tb/tb_reg_file_mp.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the multi-port register file.
package reg_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_RD_MAX = 4;

  // Bits needed to hold a count in the range 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a running count of
// set bits. Issue reserves a register, writeback releases it; when both
// hit the same register in one cycle the reservation survives because it
// belongs to a newer producer.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_clr_en,
  input  logic [ADDR_W-1:0]          i_clr_addr,
  input  logic                       i_set_en,
  input  logic [ADDR_W-1:0]          i_set_addr,
  output logic [(2**ADDR_W)-1:0]     o_pending,
  output logic [ADDR_W:0]            o_pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int CNT_W = cnt_width(DEPTH);

  logic [DEPTH-1:0] r_pend;
  logic [CNT_W-1:0] r_cnt;
  logic [DEPTH-1:0] w_pend_nxt;
  logic             w_same;
  logic             w_do_clr;
  logic             w_do_set;

  // Decide which bit actually changes; only real transitions move the count.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (which would infer a latch).
    w_pend_nxt = r_pend;
    w_same     = i_clr_en && i_set_en && (i_clr_addr == i_set_addr);
    w_do_clr   = i_clr_en && (i_clr_addr != '0) && r_pend[i_clr_addr] && !w_same;
    w_do_set   = i_set_en && (i_set_addr != '0) && !r_pend[i_set_addr];
    if (w_do_clr) w_pend_nxt[i_clr_addr] = 1'b0;
    if (w_do_set) w_pend_nxt[i_set_addr] = 1'b1;
  end

  // Pending bits and count; reset discards all outstanding reservations.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= r_cnt + CNT_W'(w_do_set) - CNT_W'(w_do_clr);
    end
  end

  assign o_pending  = r_pend;
  assign o_pend_cnt = r_cnt;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with optional write-through
// forwarding and an integrated read-after-write scoreboard. Register 0 is
// hardwired to zero and can never be reserved.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NUM_RD = 2,
  parameter bit BYPASS = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     hazard,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [ADDR_W:0]          pend_cnt
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int NRD   = (NUM_RD < NUM_RD_MAX) ? NUM_RD : NUM_RD_MAX;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  w_pend;

  // Storage update; address 0 is never written so it keeps its reset zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the array is cleared on reset, which forces plain flops rather than a RAM macro; reads after reset must see zero.
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  reg_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr_en   (wr_en),
    .i_clr_addr (wr_addr),
    .i_set_en   (iss_en),
    .i_set_addr (iss_addr),
    .o_pending  (w_pend),
    .o_pend_cnt (pend_cnt)
  );

  // Combinational read ports: zero register, then forwarding, then storage.
  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic              w_fwd;
    logic              w_live;

    assign w_ra   = rd_addr[gi*ADDR_W +: ADDR_W];
    assign w_live = rst_n && (w_ra != '0);
    assign w_fwd  = BYPASS && wr_en && (wr_addr == w_ra);

    assign rd_data[gi*DATA_W +: DATA_W] = !w_live ? '0 :
                                          w_fwd   ? wr_data : r_mem[w_ra];
    assign rd_busy[gi] = w_live && w_pend[w_ra] && !w_fwd;
  end

  assign hazard = |rd_busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp. Instance A: 32x32, two ports,
// forwarding on. Instance B: 8x32, three ports, forwarding off.
module tb_reg_file_mp;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A signals
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_hazard, a_we, a_ie;
  logic [4:0]  a_wa, a_ia;
  logic [31:0] a_wd;
  logic [5:0]  a_cnt;

  // Instance B signals
  logic [8:0]  b_rd_addr;
  logic [95:0] b_rd_data;
  logic [2:0]  b_rd_busy;
  logic        b_hazard, b_we, b_ie;
  logic [2:0]  b_wa, b_ia;
  logic [31:0] b_wd;
  logic [3:0]  b_cnt;

  int vectors = 0;
  int miscompares = 0;

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .BYPASS(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .hazard(a_hazard), .wr_en(a_we), .wr_addr(a_wa),
    .wr_data(a_wd), .iss_en(a_ie), .iss_addr(a_ia), .pend_cnt(a_cnt));

  reg_file_mp #(.DATA_W(32), .ADDR_W(3), .NUM_RD(3), .BYPASS(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
    .rd_busy(b_rd_busy), .hazard(b_hazard), .wr_en(b_we), .wr_addr(b_wa),
    .wr_data(b_wd), .iss_en(b_ie), .iss_addr(b_ia), .pend_cnt(b_cnt));

  // Reference model: architectural register contents and reservation flags.
  logic [31:0] ma [32];
  bit          pa [32];
  logic [31:0] mb [8];
  bit          pb [8];

  function automatic int pop_a();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(pa[i]);
    return n;
  endfunction

  function automatic int pop_b();
    int n = 0;
    for (int i = 0; i < 8; i++) n += int'(pb[i]);
    return n;
  endfunction

  function automatic logic [31:0] exp_data_a(input logic [4:0] ra);
    if (!rst_n || ra == 0) return 32'h0;
    if (a_we && a_wa == ra) return a_wd;
    return ma[ra];
  endfunction

  function automatic logic exp_busy_a(input logic [4:0] ra);
    return rst_n && ra != 0 && pa[ra] && !(a_we && a_wa == ra);
  endfunction

  function automatic logic [31:0] exp_data_b(input logic [2:0] ra);
    if (!rst_n || ra == 0) return 32'h0;
    return mb[ra];
  endfunction

  function automatic logic exp_busy_b(input logic [2:0] ra);
    return rst_n && ra != 0 && pb[ra];
  endfunction

  function automatic logic [31:0] a_port(input int p);
    return a_rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] b_port(input int p);
    return b_rd_data[p*32 +: 32];
  endfunction

  // One clock edge; the model absorbs the inputs the DUT saw at that edge.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin ma[i] = 0; pa[i] = 0; end
      for (int i = 0; i < 8; i++)  begin mb[i] = 0; pb[i] = 0; end
    end else begin
      if (a_we) begin
        if (a_wa != 0) ma[a_wa] = a_wd;
        pa[a_wa] = 0;
      end
      if (a_ie && a_ia != 0) pa[a_ia] = 1;
      if (b_we) begin
        if (b_wa != 0) mb[b_wa] = b_wd;
        pb[b_wa] = 0;
      end
      if (b_ie && b_ia != 0) pb[b_ia] = 1;
    end
    #1;
  endtask

  task automatic idle();
    a_we = 0; a_ie = 0; a_wa = 0; a_ia = 0; a_wd = 0;
    b_we = 0; b_ie = 0; b_wa = 0; b_ia = 0; b_wd = 0;
  endtask

  task automatic test_reset();
    idle();
    a_rd_addr = {5'd9, 5'd5};
    a_we = 1; a_wa = 5; a_wd = 32'hDEADBEEF;
    tick();
    a_we = 0; a_ie = 1; a_ia = 9;
    tick();
    a_ie = 0; #1;
    vectors++;
    if (a_port(0) !== 32'hDEADBEEF) begin miscompares++;
      $display("FAIL reset_prewrite: got %h want %h", a_port(0), 32'hDEADBEEF); end
    vectors++;
    if (a_cnt !== 6'd1) begin miscompares++;
      $display("FAIL reset_precnt: got %0d want 1", a_cnt); end
    rst_n = 0; a_we = 1; a_wa = 6; a_wd = 32'h12345678; a_ie = 1; a_ia = 10;
    #1;
    vectors++;
    if (a_port(0) !== 32'h0 || a_rd_busy !== 2'b00 || a_hazard !== 1'b0) begin miscompares++;
      $display("FAIL reset_forced: data %h busy %b hazard %b want 0", a_port(0), a_rd_busy, a_hazard); end
    tick();
    rst_n = 1; idle(); a_rd_addr = {5'd6, 5'd5}; #1;
    vectors++;
    if (a_port(0) !== 32'h0 || a_port(1) !== 32'h0) begin miscompares++;
      $display("FAIL reset_storage: r5 %h r6 %h want 0", a_port(0), a_port(1)); end
    vectors++;
    if (a_cnt !== 6'd0 || a_hazard !== 1'b0) begin miscompares++;
      $display("FAIL reset_sb: cnt %0d hazard %b want 0", a_cnt, a_hazard); end
  endtask

  task automatic test_reg0();
    idle();
    a_rd_addr = 10'd0;
    a_we = 1; a_wa = 0; a_wd = 32'hFFFFFFFF; #1;
    vectors++;
    if (a_port(0) !== 32'h0 || a_port(1) !== 32'h0) begin miscompares++;
      $display("FAIL reg0_bypass: p0 %h p1 %h want 0", a_port(0), a_port(1)); end
    tick();
    a_we = 0; a_ie = 1; a_ia = 0;
    tick();
    a_ie = 0; #1;
    vectors++;
    if (a_port(0) !== 32'h0 || a_port(1) !== 32'h0) begin miscompares++;
      $display("FAIL reg0_read: p0 %h p1 %h want 0", a_port(0), a_port(1)); end
    vectors++;
    if (a_cnt !== 6'd0 || a_rd_busy !== 2'b00) begin miscompares++;
      $display("FAIL reg0_pend: cnt %0d busy %b want 0", a_cnt, a_rd_busy); end
  endtask

  task automatic test_bypass();
    idle();
    a_we = 1; a_wa = 7; a_wd = 32'h11;
    b_we = 1; b_wa = 7; b_wd = 32'h11;
    tick();
    idle(); a_ie = 1; a_ia = 7; b_ie = 1; b_ia = 7;
    tick();
    idle();
    a_rd_addr = {5'd0, 5'd7}; b_rd_addr = {3'd0, 3'd0, 3'd7};
    a_we = 1; a_wa = 7; a_wd = 32'h22;
    b_we = 1; b_wa = 7; b_wd = 32'h22;
    #1;
    vectors++;
    if (a_port(0) !== 32'h22 || a_rd_busy[0] !== 1'b0) begin miscompares++;
      $display("FAIL bypass_on: data %h busy %b want 22/0", a_port(0), a_rd_busy[0]); end
    vectors++;
    if (b_port(0) !== 32'h11 || b_rd_busy[0] !== 1'b1) begin miscompares++;
      $display("FAIL bypass_off_same: data %h busy %b want 11/1", b_port(0), b_rd_busy[0]); end
    tick();
    idle(); #1;
    vectors++;
    if (b_port(0) !== 32'h22 || b_rd_busy[0] !== 1'b0) begin miscompares++;
      $display("FAIL bypass_off_next: data %h busy %b want 22/0", b_port(0), b_rd_busy[0]); end
    vectors++;
    if (a_port(0) !== 32'h22 || a_cnt !== 6'd0 || b_cnt !== 4'd0) begin miscompares++;
      $display("FAIL bypass_after: a %h acnt %0d bcnt %0d want 22/0/0", a_port(0), a_cnt, b_cnt); end
  endtask

  task automatic test_scoreboard();
    idle();
    a_rd_addr = {5'd0, 5'd3};
    a_ie = 1; a_ia = 3;
    #1;
    vectors++;
    if (a_rd_busy[0] !== 1'b0) begin miscompares++;
      $display("FAIL sb_issue_same: busy %b want 0", a_rd_busy[0]); end
    tick();
    idle(); #1;
    vectors++;
    if (a_rd_busy[0] !== 1'b1 || a_hazard !== 1'b1 || a_cnt !== 6'd1) begin miscompares++;
      $display("FAIL sb_busy: busy %b hazard %b cnt %0d want 1/1/1", a_rd_busy[0], a_hazard, a_cnt); end
    a_we = 1; a_wa = 3; a_wd = 32'h33; #1;
    vectors++;
    if (a_rd_busy[0] !== 1'b0 || a_hazard !== 1'b0) begin miscompares++;
      $display("FAIL sb_fwd_clear: busy %b hazard %b want 0", a_rd_busy[0], a_hazard); end
    tick();
    idle(); #1;
    vectors++;
    if (a_rd_busy[0] !== 1'b0 || a_cnt !== 6'd0 || a_port(0) !== 32'h33) begin miscompares++;
      $display("FAIL sb_released: busy %b cnt %0d data %h want 0/0/33", a_rd_busy[0], a_cnt, a_port(0)); end
  endtask

  task automatic test_simultaneous();
    idle();
    a_rd_addr = {5'd0, 5'd4};
    a_ie = 1; a_ia = 4;
    tick();
    idle();
    a_we = 1; a_wa = 4; a_wd = 32'hCAFE0004; a_ie = 1; a_ia = 4;
    tick();
    idle(); #1;
    vectors++;
    if (a_rd_busy[0] !== 1'b1 || a_cnt !== 6'd1) begin miscompares++;
      $display("FAIL simul_pend: busy %b cnt %0d want 1/1", a_rd_busy[0], a_cnt); end
    vectors++;
    if (a_port(0) !== 32'hCAFE0004) begin miscompares++;
      $display("FAIL simul_store: got %h want cafe0004", a_port(0)); end
    a_we = 1; a_wa = 4; a_wd = 32'h44;
    tick();
    idle(); #1;
    vectors++;
    if (a_cnt !== 6'd0) begin miscompares++;
      $display("FAIL simul_drain: cnt %0d want 0", a_cnt); end
  endtask

  task automatic test_saturation();
    idle();
    b_rd_addr = {3'd7, 3'd1, 3'd0};
    for (int i = 1; i < 8; i++) begin
      b_ie = 1; b_ia = 3'(i);
      tick();
    end
    idle(); #1;
    vectors++;
    if (b_cnt !== 4'd7 || b_rd_busy !== 3'b110 || b_hazard !== 1'b1) begin miscompares++;
      $display("FAIL sat_full: cnt %0d busy %b hazard %b want 7/110/1", b_cnt, b_rd_busy, b_hazard); end
    b_ie = 1; b_ia = 7;
    tick();
    idle(); #1;
    vectors++;
    if (b_cnt !== 4'd7) begin miscompares++;
      $display("FAIL sat_reissue: cnt %0d want 7", b_cnt); end
    for (int i = 1; i < 8; i++) begin
      b_we = 1; b_wa = 3'(i); b_wd = 32'(i * 16);
      tick();
    end
    idle(); #1;
    vectors++;
    if (b_cnt !== 4'd0 || b_hazard !== 1'b0) begin miscompares++;
      $display("FAIL sat_drain: cnt %0d hazard %b want 0/0", b_cnt, b_hazard); end
    b_we = 1; b_wa = 5; b_wd = 32'h55;
    tick();
    idle(); #1;
    vectors++;
    if (b_cnt !== 4'd0) begin miscompares++;
      $display("FAIL sat_nowrap: cnt %0d want 0", b_cnt); end
  endtask

  task automatic test_random();
    logic [4:0] ra;
    logic [2:0] rb;
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      a_we = 1'($urandom); a_ie = 1'($urandom); a_wd = $urandom;
      a_wa = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a_ia = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a_rd_addr = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      b_we = 1'($urandom); b_ie = 1'($urandom); b_wd = $urandom;
      b_wa = 3'($urandom); b_ia = 3'($urandom);
      b_rd_addr = 9'($urandom);
      #1;
      for (int p = 0; p < 2; p++) begin
        ra = a_rd_addr[p*5 +: 5];
        vectors++;
        if (a_port(p) !== exp_data_a(ra) || a_rd_busy[p] !== exp_busy_a(ra)) begin miscompares++;
          $display("FAIL rand_a_port%0d cyc %0d addr %0d: data %h busy %b want %h/%b",
                   p, n, ra, a_port(p), a_rd_busy[p], exp_data_a(ra), exp_busy_a(ra)); end
      end
      for (int p = 0; p < 3; p++) begin
        rb = b_rd_addr[p*3 +: 3];
        vectors++;
        if (b_port(p) !== exp_data_b(rb) || b_rd_busy[p] !== exp_busy_b(rb)) begin miscompares++;
          $display("FAIL rand_b_port%0d cyc %0d addr %0d: data %h busy %b want %h/%b",
                   p, n, rb, b_port(p), b_rd_busy[p], exp_data_b(rb), exp_busy_b(rb)); end
      end
      vectors++;
      if (a_hazard !== (|a_rd_busy) || b_hazard !== (|b_rd_busy)) begin miscompares++;
        $display("FAIL rand_hazard cyc %0d: a %b b %b", n, a_hazard, b_hazard); end
      vectors++;
      if (a_cnt !== 6'(pop_a()) || b_cnt !== 4'(pop_b())) begin miscompares++;
        $display("FAIL rand_cnt cyc %0d: a %0d b %0d want %0d/%0d", n, a_cnt, b_cnt, pop_a(), pop_b()); end
      tick();
    end
    rst_n = 1; idle();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 0; idle();
    a_rd_addr = '0; b_rd_addr = '0;
    tick(); tick();
    rst_n = 1;
    test_reset();
    test_reg0();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
